// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB3 requester with valid/ready command and response ports.
// Optional ACCESS-phase watchdog is compiled in when APB_TIMEOUT_EN is defined.
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // SETUP  | psel high, penable low, exactly one cycle
    // ACCESS | psel and penable high until pready (or watchdog abort)
    // RESP   | response held on rsp_* until rsp_ready
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   done;
    logic   wd_hit;

    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && pready;
    assign cmd_ready = resetn && (state == IDLE);
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

`ifdef APB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_cnt;
    logic            rsp_to_q;

    // pready takes priority: a limit cycle with pready high completes normally
    assign wd_hit = (state == ACCESS) && !pready && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt   <= '0;
            rsp_to_q <= 1'b0;
        end else begin
            if (accept)
                wd_cnt <= '0;
            else if ((state == ACCESS) && !pready)
                wd_cnt <= wd_cnt + WD_W'(1);
            if (done)
                rsp_to_q <= 1'b0;
            else if (wd_hit)
                rsp_to_q <= 1'b1;
        end
    end

    assign rsp_timeout = rsp_to_q;
`else
    assign wd_hit      = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done || wd_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bus fields hold their last value between transfers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (wd_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: cycle-timeline model of each transfer plus literal checks.
// Build with APB_TIMEOUT_EN defined to exercise the watchdog abort path.
module tb_apb_master_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int checks = 0;
    int failures = 0;

    // model of the transfer in flight
    bit            exp_active = 1'b0;
    int            k = 0;
    int            n_acc = 0;
    int            slv_waits = 0;
    int            slv_acc = 0;
    logic          cur_write, cur_err, cur_to;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, cur_rd;

    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // slave: pready after slv_waits wait states; junk data/error outside the ready cycle
    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = (slv_acc == slv_waits);
            prdata  = pready ? cur_rd : (32'hA5A5_0000 + DW'(slv_acc));
            pslverr = pready ? cur_err : 1'b1;
            slv_acc++;
        end else begin
            pready  = 1'b0;
            prdata  = 32'hFFFF_FFFF;
            pslverr = 1'b1;
            slv_acc = 0;
        end
    end

    // per-cycle compare: cycle k after accept is SETUP at 1, ACCESS for n_acc cycles, then RESP
    always @(negedge clk) begin
        logic es, ee, ev;
        if (!resetn) begin
            check("rst_psel", psel, 0);
            check("rst_penable", penable, 0);
            check("rst_pwrite", pwrite, 0);
            check("rst_paddr", paddr, 0);
            check("rst_pwdata", pwdata, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_rsp_timeout", rsp_timeout, 0);
            check("rst_cmd_ready", cmd_ready, 0);
        end else if (exp_active) begin
            k++;
            if (k == 1) begin es = 1; ee = 0; ev = 0; end
            else if (k <= 1 + n_acc) begin es = 1; ee = 1; ev = 0; end
            else begin es = 0; ee = 0; ev = 1; end
            check("busy_cmd_ready", cmd_ready, 0);
            check("psel", psel, es);
            check("penable", penable, ee);
            check("rsp_valid", rsp_valid, ev);
            if (psel) begin
                check("paddr", paddr, cur_addr);
                check("pwrite", pwrite, cur_write);
                check("pwdata", pwdata, cur_wdata);
            end
            if (rsp_valid) begin
                check("rsp_rdata", rsp_rdata, (cur_to || cur_write) ? '0 : cur_rd);
                check("rsp_err", rsp_err, cur_to | cur_err);
                check("rsp_timeout", rsp_timeout, cur_to);
            end
        end else begin
            check("idle_psel", psel, 0);
            check("idle_penable", penable, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_cmd_ready", cmd_ready, 1);
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int waits, input logic [DW-1:0] rd, input logic err,
                            input bit stuck, input bit hold, output bit ok, output int wait_acc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        wait_acc = 0;
        while (!cmd_ready && wait_acc < 50) begin
            @(negedge clk);
            wait_acc++;
        end
        ok = cmd_ready;
        if (!ok) begin
            check("accept_bound", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        cur_write = w; cur_addr = a; cur_wdata = d; cur_rd = rd; cur_err = err;
        cur_to    = stuck && TO_EN;
        slv_waits = stuck ? 1_000_000 : waits;
        n_acc     = stuck ? (TO_EN ? TO : 1_000_000) : waits + 1;
        k = 0;
        exp_active = 1'b1;
        #1;
        if (hold) begin
            cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic [DW-1:0] rd, input logic err,
                        input int rdelay, input bit hold, input bit stuck,
                        output int lat, output int pen, output logic [DW-1:0] got_rd,
                        output logic got_err, output logic got_to, output int wait_acc);
        bit ok;
        lat = 0; pen = 0; got_rd = 'x; got_err = 1'bx; got_to = 1'bx;
        send_cmd(w, a, d, waits, rd, err, stuck, hold, ok, wait_acc);
        if (!ok) return;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (penable) pen++;
        end
        if (!rsp_valid) begin
            check("rsp_bound", 0, 1);
            exp_active = 1'b0;
            return;
        end
        got_rd = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
        repeat (rdelay) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        exp_active = 1'b0;
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, pen, wa;
        logic [DW-1:0] rd;
        logic er, to;
        bit ok;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;

        // zero-wait write
        xfer(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_CAFE, 0, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("t1_latency", lat, 3);
        check("t1_penable_cycles", pen, 1);
        check("t1_rdata", rd, 0);
        check("t1_err", er, 0);

        // read with 3 wait states
        xfer(0, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 0, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("t2_penable_cycles", pen, 4);
        check("t2_latency", lat, 6);
        check("t2_rdata", rd, 32'h1234_5678);

        // read with slave error
        xfer(0, 32'h0000_0030, 32'h0, 1, 32'h55AA_55AA, 1, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("t3_err", er, 1);
        check("t3_timeout", to, 0);
        check("t3_rdata", rd, 32'h55AA_55AA);

        // write with slave error returns zero data
        xfer(1, 32'h0000_0044, 32'h0102_0304, 2, 32'h0000_0077, 1, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("tw_rdata", rd, 0);
        check("tw_err", er, 1);

        // response back-pressure with cmd_valid held, then immediate next command
        xfer(0, 32'h0000_0050, 32'h0, 0, 32'h0BAD_F00D, 0, 5, 1, 0, lat, pen, rd, er, to, wa);
        check("t4_rdata", rd, 32'h0BAD_F00D);
        xfer(1, 32'h0000_0054, 32'h1111_2222, 0, 32'h0000_0033, 0, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("t4_next_accept_wait", wa, 0);
        check("t4_next_latency", lat, 3);

        // pready on the 16th ACCESS cycle completes normally
        xfer(0, 32'h0000_0060, 32'h0, 15, 32'hFEED_FACE, 0, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("tb_penable_cycles", pen, 16);
        check("tb_rdata", rd, 32'hFEED_FACE);
        check("tb_timeout", to, 0);

        // reset during ACCESS
        send_cmd(0, 32'h0000_0070, 32'h0, 5, 32'h0000_0001, 0, 0, 0, ok, wa);
        repeat (3) @(negedge clk);
        check("t5_in_access", psel && penable, 1);
        #1 exp_active = 1'b0;
        resetn = 1'b0;
        #1;
        check("t5_async_psel", psel, 0);
        check("t5_async_penable", penable, 0);
        check("t5_async_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1 resetn = 1'b1;
        xfer(0, 32'h0000_0074, 32'h0, 2, 32'h600D_CAFE, 0, 0, 0, 0, lat, pen, rd, er, to, wa);
        check("t5_after_rdata", rd, 32'h600D_CAFE);
        check("t5_after_latency", lat, 5);

        // pready stuck low
`ifdef APB_TIMEOUT_EN
        xfer(0, 32'h0000_0080, 32'h0, 0, 32'h9999_9999, 0, 0, 0, 1, lat, pen, rd, er, to, wa);
        check("t6_penable_cycles", pen, 16);
        check("t6_latency", lat, 18);
        check("t6_rdata", rd, 0);
        check("t6_err", er, 1);
        check("t6_timeout", to, 1);
`else
        send_cmd(0, 32'h0000_0080, 32'h0, 0, 32'h9999_9999, 0, 1, 0, ok, wa);
        repeat (40) @(negedge clk);
        #1;
        check("t6_still_access", psel && penable, 1);
        check("t6_no_rsp", rsp_valid, 0);
        exp_active = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        #1 resetn = 1'b1;
`endif
        xfer(1, 32'h0000_0090, 32'hABCD_0123, 1, 32'h0000_0044, 0, 1, 0, 0, lat, pen, rd, er, to, wa);
        check("t7_err", er, 0);
        check("t7_timeout", to, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end
endmodule
